// File: rtl/demux1_2_buf_pkg.sv
// Shared types for the 1:2 buffered demultiplexer.
// Provides the word type, the destination-select enum and the default
// FIFO geometry used by the interface, the FIFO and the top level.
package demux_pkg;

  localparam int WORD_W     = 12;
  localparam int FIFO_DEPTH = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

endpackage

// File: rtl/demux1_2_buf_if.sv
// Bus bundle for demux1_2_buf.
// Producer side : in_data, in_sel, in_valid -> block; in_ready <- block.
// Consumer A/B  : outN_data, outN_valid <- block; outN_ready -> block.
// Status        : count0/count1 occupancy of FIFO A/B <- block.
// master = the environment (producer + consumers), slave = the block.
interface demux1_2_buf_if
  import demux_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, count0, count1
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, count0, count1
  );

endinterface

// File: rtl/demux1_2_buf_fifo.sv
// sync_fifo: small in-order synchronous FIFO, one per demux destination.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i/data_i write request and word (ignored while full)
//   pop_i         read request (ignored while empty)
//   full_o        count == DEPTH
//   empty_o       count == 0
//   count_o       registered occupancy, one bit wider than the pointers
//   head_o        word at the read pointer (meaningful only when !empty_o)
module sync_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en_s;
  logic             pop_en_s;

  // Status flags come straight from the registered count.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    push_en_s = push_i & ~full_o;
    pop_en_s  = pop_i & ~empty_o;

    if (push_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;  // idle, or push and pop together
    endcase
  end

  // State registers; storage is also cleared so no earlier word survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/demux1_2_buf.sv
// demux1_2_buf: routes one producer word stream to lane A or lane B,
// chosen per word by in_sel, with a small in-order FIFO per lane so a
// stalled consumer never blocks or corrupts the other lane.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, discards all queued words
//   bus  demux1_2_buf_if.slave: producer handshake, two consumer
//        handshakes and per-lane occupancy counts
module demux1_2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  demux1_2_buf_if.slave     bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  sel_t             sel_s;
  logic             in_ready_s;
  logic             push0_s, push1_s;
  logic             pop0_s, pop1_s;
  logic             full0_s, full1_s;
  logic             empty0_s, empty1_s;
  logic [CNT_W-1:0] count0_s, count1_s;
  logic [WIDTH-1:0] head0_s, head1_s;

  assign sel_s = sel_t'(bus.in_sel);

  // Ready reflects only the selected lane's registered fullness, never in_valid,
  // so a pop in the same cycle cannot reopen a full lane.
  always_comb begin
    case (sel_s)
      SEL_A:   in_ready_s = ~full0_s;
      SEL_B:   in_ready_s = ~full1_s;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Push decode: an accepted word goes to exactly one lane.
  always_comb begin
    if (bus.in_valid && in_ready_s) begin
      push0_s = (sel_s == SEL_A);
      push1_s = (sel_s == SEL_B);
    end else begin
      push0_s = 1'b0;
      push1_s = 1'b0;
    end
  end

  // Pops only count when the lane actually has a head word.
  always_comb begin
    pop0_s = bus.out0_ready & ~empty0_s;
    pop1_s = bus.out1_ready & ~empty1_s;
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push0_s),
    .data_i  (bus.in_data),
    .pop_i   (pop0_s),
    .full_o  (full0_s),
    .empty_o (empty0_s),
    .count_o (count0_s),
    .head_o  (head0_s)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push1_s),
    .data_i  (bus.in_data),
    .pop_i   (pop1_s),
    .full_o  (full1_s),
    .empty_o (empty1_s),
    .count_o (count1_s),
    .head_o  (head1_s)
  );

  // Output zero-gating: an empty lane drives an all-zero data bus.
  always_comb begin
    if (!empty0_s) begin
      bus.out0_data = head0_s;
    end else begin
      bus.out0_data = {WIDTH{1'b0}};
    end
    if (!empty1_s) begin
      bus.out1_data = head1_s;
    end else begin
      bus.out1_data = {WIDTH{1'b0}};
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out0_valid = ~empty0_s;
  assign bus.out1_valid = ~empty1_s;
  assign bus.count0     = count0_s;
  assign bus.count1     = count1_s;

endmodule

// File: tb/tb_demux1_2_buf.sv
// Self-checking bench for demux1_2_buf: a directed vector table for reset,
// routing, back-pressure and same-edge push/pop, then a randomised
// order/wrap sequence against queue models, then a mid-operation reset.
module tb_demux1_2_buf;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  demux1_2_buf_if #(.WIDTH(12), .DEPTH(2)) bus ();

  demux1_2_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic        sel;
    logic [11:0] data;
    logic        r0;
    logic        r1;
    logic        chk_rdy;
    logic        rdy;
    logic        v0;
    logic [11:0] d0;
    logic [1:0]  c0;
    logic        v1;
    logic [11:0] d1;
    logic [1:0]  c1;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic rs, input logic vl, input logic sl,
                              input logic [11:0] dt, input logic a_r, input logic b_r,
                              input logic ck, input logic rd,
                              input logic ev0, input logic [11:0] ed0, input logic [1:0] ec0,
                              input logic ev1, input logic [11:0] ed1, input logic [1:0] ec1);
    vec_t v;
    v.rst = rs; v.vld = vl; v.sel = sl; v.data = dt; v.r0 = a_r; v.r1 = b_r;
    v.chk_rdy = ck; v.rdy = rd;
    v.v0 = ev0; v.d0 = ed0; v.c0 = ec0;
    v.v1 = ev1; v.d1 = ed1; v.c1 = ec1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic vl, input logic sl,
                       input logic [11:0] dt, input logic a_r, input logic b_r);
    rst            = rs;
    bus.in_valid   = vl;
    bus.in_sel     = sl;
    bus.in_data    = dt;
    bus.out0_ready = a_r;
    bus.out1_ready = b_r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] q0 [$];
  logic [11:0] q1 [$];

  initial begin
    int          sent;
    int          popped;
    logic        pend;
    logic        cur_sel;
    logic [11:0] cur_data;
    logic        a_r, b_r, exp_rdy;
    int          cyc;

    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

    //           rst   vld   sel   data    r0    r1    chk   rdy   v0    d0      c0     v1    d1      c1
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 12'h111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 12'h222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 12'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 2'd1, 1'b0, 12'h000, 2'd0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 12'h3C3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 2'd1, 1'b1, 12'h3C3, 2'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 12'h101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 2'd2, 1'b1, 12'h3C3, 2'd1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 12'h102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0A5, 2'd2, 1'b1, 12'h3C3, 2'd1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 12'h201, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 2'd2, 1'b1, 12'h3C3, 2'd2);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 12'h102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h101, 2'd1, 1'b1, 12'h3C3, 2'd2);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 12'h102, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h101, 2'd2, 1'b1, 12'h3C3, 2'd2);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h102, 2'd1, 1'b1, 12'h3C3, 2'd2);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 12'h103, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h103, 2'd1, 1'b1, 12'h3C3, 2'd2);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 1'b1, 12'h201, 2'd1);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0);

    // Directed table: drive, check combinational ready, clock, check registered outputs.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].r0, tbl[i].r1);
      #1;
      if (tbl[i].chk_rdy) chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("v%0d out0_valid", i), 32'(bus.out0_valid), 32'(tbl[i].v0));
      chk($sformatf("v%0d out0_data", i),  32'(bus.out0_data),  32'(tbl[i].d0));
      chk($sformatf("v%0d count0", i),     32'(bus.count0),     32'(tbl[i].c0));
      chk($sformatf("v%0d out1_valid", i), 32'(bus.out1_valid), 32'(tbl[i].v1));
      chk($sformatf("v%0d out1_data", i),  32'(bus.out1_data),  32'(tbl[i].d1));
      chk($sformatf("v%0d count1", i),     32'(bus.count1),     32'(tbl[i].c1));
    end

    // Random routing and back-pressure against two queue models; 40 words.
    sent = 0; popped = 0; pend = 1'b0; cur_sel = 1'b0; cur_data = 12'h000;
    cyc = 0;
    while ((sent < 40) && (cyc < 2000)) begin
      if (!pend) begin
        cur_sel  = 1'($urandom_range(0, 1));
        cur_data = 12'($urandom_range(0, 4095));
        pend     = 1'b1;
      end
      a_r = 1'($urandom_range(0, 1));
      b_r = 1'($urandom_range(0, 1));
      drive(1'b0, 1'b1, cur_sel, cur_data, a_r, b_r);
      #1;
      exp_rdy = cur_sel ? (q1.size() < 2) : (q0.size() < 2);
      chk("rnd in_ready",   32'(bus.in_ready),   32'(exp_rdy));
      chk("rnd count0",     32'(bus.count0),     32'(q0.size()));
      chk("rnd count1",     32'(bus.count1),     32'(q1.size()));
      chk("rnd out0_data",  32'(bus.out0_data),  (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
      chk("rnd out1_data",  32'(bus.out1_data),  (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
      chk("rnd out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
      chk("rnd out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
      tick();
      if (a_r && (q0.size() != 0)) begin void'(q0.pop_front()); popped++; end
      if (b_r && (q1.size() != 0)) begin void'(q1.pop_front()); popped++; end
      if (exp_rdy) begin
        if (cur_sel) q1.push_back(cur_data);
        else         q0.push_back(cur_data);
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    chk("rnd words sent", 32'(sent), 32'd40);

    // Drain both lanes, still checking head order every cycle.
    cyc = 0;
    while (((q0.size() != 0) || (q1.size() != 0)) && (cyc < 20)) begin
      drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      #1;
      chk("drain out0_data", 32'(bus.out0_data), (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
      chk("drain out1_data", 32'(bus.out1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
      tick();
      if (q0.size() != 0) begin void'(q0.pop_front()); popped++; end
      if (q1.size() != 0) begin void'(q1.pop_front()); popped++; end
      cyc++;
    end
    chk("drain words out", 32'(popped), 32'd40);
    chk("drain count0", 32'(bus.count0), 32'd0);
    chk("drain count1", 32'(bus.count1), 32'd0);

    // Mid-operation reset with both lanes full.
    drive(1'b0, 1'b1, 1'b0, 12'h5A1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 12'h5A2, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 12'h6B1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 12'h6B2, 1'b0, 1'b0); tick();
    chk("mid full count0", 32'(bus.count0), 32'd2);
    chk("mid full count1", 32'(bus.count1), 32'd2);
    chk("mid full out1_data", 32'(bus.out1_data), 32'h6B1);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0); tick();
    chk("mid rst count0", 32'(bus.count0), 32'd0);
    chk("mid rst count1", 32'(bus.count1), 32'd0);
    chk("mid rst out0_valid", 32'(bus.out0_valid), 32'd0);
    chk("mid rst out1_valid", 32'(bus.out1_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      #1;
      chk("post rst in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("post rst out0_data", 32'(bus.out0_data), 32'h0);
      chk("post rst out1_data", 32'(bus.out1_data), 32'h0);
      chk("post rst out0_valid", 32'(bus.out0_valid), 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 12'h777, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("post rst new head", 32'(bus.out0_data), 32'h777);
    chk("post rst new count0", 32'(bus.count0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
